cdc_2phase_src_arbiter: RTL
===========================

Name: cdc_2phase_src_arbiter

Overview:
Round-robin arbiter that shares one two-phase CDC source half between NUM_REQ requesters in the source clock domain. It accepts one item at a time into a single-entry holding register and presents it, tagged with the requester index, to the CDC source valid/ready port. It also sequences the CDC clear. Valid is never raised while clear is active. A watchdog self-clears the channel if the far side stops acknowledging.

Parameters:
NUM_REQ, 4, number of requesters (≥2)
DATA_WIDTH, 1, payload width per requester
IDX_WIDTH, $clog2(NUM_REQ), requester index width (derived, not to be overridden)
TIMEOUT, 64, cycles cdc_valid_o may stay high without cdc_ready_i before a forced clear; 0 disables the watchdog
CLEAR_CYCLES, 2, minimum cycles cdc_clear_o stays asserted per clear sequence (≥1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
req_valid_i  in  NUM_REQ  per-requester valid
req_data_i  in  NUM_REQ*DATA_WIDTH  per-requester payload; requester k uses slice [k*DATA_WIDTH +: DATA_WIDTH]
req_ready_o  out  NUM_REQ  per-requester accept; one-hot or zero
clear_i  in  1  clear request from the local clear controller
cdc_valid_o  out  1  to CDC source valid
cdc_data_o  out  DATA_WIDTH  to CDC source data
cdc_idx_o  out  IDX_WIDTH  index of the requester owning cdc_data_o
cdc_ready_i  in  1  from CDC source ready
cdc_clear_o  out  1  to CDC source clear
busy_o  out  1  state != IDLE
drop_o  out  1  one-cycle pulse when a held item is discarded by a clear or a timeout
timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset (rst_ni=0 at posedge): state IDLE; rr pointer=0; hold data/idx=0; watchdog and clear counters=0. All outputs 0 while in reset and in the first cycle after.
- State IDLE:
  - If clear_i=1: no grant; all req_ready_o=0; next state CLEAR. Clear wins over pending requests in the same cycle.
  - Else, if any req_valid_i: the winner is the first set bit searching upward from the pointer, wrapping modulo NUM_REQ.
  - req_ready_o[winner]=1 combinationally in that cycle. Latch the winner's data and index; next state GRANT.
  - req_ready_o depends only on state, clear_i, req_valid_i and the pointer, never on cdc_ready_i.
- State GRANT:
  - cdc_valid_o=1; cdc_data_o/cdc_idx_o are the latched values, stable until the handshake. All req_ready_o=0.
  - Priority order: clear_i, then handshake, then timeout.
  - clear_i=1: cdc_valid_o=0 in that cycle (combinationally masked), drop_o=1, next state CLEAR. This holds even if cdc_ready_i=1.
  - cdc_valid_o & cdc_ready_i: transfer done. Pointer = (idx+1) mod NUM_REQ; next state IDLE.
  - Watchdog: counts GRANT cycles without a handshake, reset to 0 on entering GRANT.
  - If TIMEOUT>0 and the count equals TIMEOUT-1 with no handshake and no clear: timeout_o=1, drop_o=1, next state CLEAR.
  - Every drop (clear or timeout) also sets pointer = (idx+1) mod NUM_REQ.
- State CLEAR:
  - cdc_clear_o=1, cdc_valid_o=0, all req_ready_o=0. Clear counter counts from 0 on entry.
  - Exit to IDLE once the counter has reached CLEAR_CYCLES-1 and clear_i=0. Otherwise remain in CLEAR.
  - clear_i re-asserting before exit keeps the block in CLEAR with no restart penalty.
- Latency: requester accepted at cycle N gives cdc_valid_o=1 at N+1. Handshake at M gives IDLE at M+1, with the next accept possible at M+1. Peak throughput is one item per 2 cycles.
- Invariants:
  - cdc_valid_o & cdc_clear_o never both 1.
  - cdc_valid_o never 1 in a cycle with clear_i=1.
  - At most one req_ready_o bit set.
  - cdc_data_o/cdc_idx_o never change while cdc_valid_o=1 and cdc_ready_i=0.
- Reset mid-operation: a held item is silently lost (no drop_o); outputs return to reset values at the next posedge.

Test Plan:
- Fairness: NUM_REQ=4, all req_valid_i=1 constantly, cdc_ready_i=1. Grants must be idx 0,1,2,3,0, one every 2 cycles. cdc_data_o must match each requester's slice.
- Latency/backpressure: req 2 valid at cycle 5, cdc_ready_i low until cycle 12. Then req_ready_o[2]=1 at 5, cdc_valid_o=1 at cycles 6–12, data stable, IDLE at 13.
- Clear during GRANT: item from req 1 held, clear_i=1 for 1 cycle with cdc_ready_i=1. Required: cdc_valid_o=0 that cycle, drop_o=1, cdc_clear_o=1 for exactly CLEAR_CYCLES=2 cycles, next grant starts at idx 2.
- Clear in IDLE with pending request: clear_i=1 and req_valid_i=4'b0001 in the same cycle. Required: req_ready_o=0, CLEAR entered, req 0 granted after the clear ends.
- Watchdog: TIMEOUT=8, cdc_ready_i held 0. Required: timeout_o and drop_o pulse on the 8th GRANT cycle, then cdc_clear_o=1 for 2 cycles, then IDLE. With TIMEOUT=0, GRANT holds indefinitely.
- Sync reset: rst_ni=0 for one cycle while in GRANT. Required: all outputs 0 at the next cycle, pointer=0, so the first grant afterwards goes to the lowest valid index.

Source files
------------

// File: rtl/cdc_2phase_src_arbiter.sv
// cdc_2phase_src_arbiter
//   Round-robin arbiter sharing one two-phase CDC source half between
//   NUM_REQ requesters. One item at a time is latched into a single-entry
//   holding register and presented, tagged with its requester index, on the
//   CDC valid/ready port. The block also sequences the CDC clear and runs a
//   watchdog that force-clears the channel when the far side stalls.
//
// Ports:
//   clk_i, rst_ni   clock, synchronous active-low reset
//   req_valid_i     per-requester valid
//   req_data_i      per-requester payload, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   req_ready_o     per-requester accept (one-hot or zero)
//   clear_i         clear request from the local clear controller
//   cdc_valid_o     CDC source valid (never high together with clear)
//   cdc_data_o      held payload
//   cdc_idx_o       index of the requester owning cdc_data_o
//   cdc_ready_i     CDC source ready
//   cdc_clear_o     CDC source clear
//   busy_o          arbiter not idle
//   drop_o          pulse when a held item is discarded (clear or timeout)
//   timeout_o       pulse when the watchdog fires
module cdc_2phase_src_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_WIDTH   = 1,
  parameter int unsigned IDX_WIDTH    = $clog2(NUM_REQ),
  parameter int unsigned TIMEOUT      = 64,
  parameter int unsigned CLEAR_CYCLES = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          clear_i,
  output logic                          cdc_valid_o,
  output logic [DATA_WIDTH-1:0]         cdc_data_o,
  output logic [IDX_WIDTH-1:0]          cdc_idx_o,
  input  logic                          cdc_ready_i,
  output logic                          cdc_clear_o,
  output logic                          busy_o,
  output logic                          drop_o,
  output logic                          timeout_o
);

  // Counter widths sized to reach TIMEOUT-1 / CLEAR_CYCLES-1; never zero width.
  localparam int unsigned WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned WD_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam bit          WD_EN   = (TIMEOUT > 0);
  localparam int unsigned CL_W    = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam int unsigned CL_LAST = (CLEAR_CYCLES > 0) ? CLEAR_CYCLES - 1 : 0;
  localparam logic [IDX_WIDTH-1:0] IDX_MAX = IDX_WIDTH'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  state_e                 state_r, state_nxt_s;
  logic                   live_r;
  logic [IDX_WIDTH-1:0]   ptr_r;
  logic [IDX_WIDTH-1:0]   hold_idx_r;
  logic [DATA_WIDTH-1:0]  hold_data_r;
  logic [WD_W-1:0]        wd_cnt_r;
  logic [CL_W-1:0]        clr_cnt_r;

  logic                   win_found_s;
  logic [IDX_WIDTH-1:0]   win_idx_s;
  logic                   accept_s;
  logic                   handshake_s;
  logic                   wd_fire_s;
  logic                   drop_s;
  logic                   clr_done_s;
  logic [IDX_WIDTH-1:0]   ptr_adv_s;

  function automatic logic [IDX_WIDTH-1:0] rr_wrap(input int unsigned v);
    return IDX_WIDTH'(v % NUM_REQ);
  endfunction

  // Round-robin search: first valid requester at or above the pointer, wrapping.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!win_found_s && req_valid_i[rr_wrap(32'(ptr_r) + i)]) begin
        win_found_s = 1'b1;
        win_idx_s   = rr_wrap(32'(ptr_r) + i);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Event decode. live_r holds off grants in the first cycle after reset;
  // the clear counter saturates, so equality marks "minimum time served".
  always_comb begin
    accept_s    = (state_r == ST_IDLE) && live_r && !clear_i && win_found_s;
    handshake_s = (state_r == ST_GRANT) && !clear_i && cdc_ready_i;
    wd_fire_s   = WD_EN && (state_r == ST_GRANT) && !clear_i && !cdc_ready_i &&
                  (wd_cnt_r == WD_W'(WD_LAST));
    drop_s      = (state_r == ST_GRANT) && (clear_i || wd_fire_s);
    clr_done_s  = (clr_cnt_r == CL_W'(CL_LAST));
    ptr_adv_s   = (hold_idx_r == IDX_MAX) ? '0 : hold_idx_r + IDX_WIDTH'(1);
  end

  // Next-state logic; priority in GRANT is clear, handshake, timeout.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!live_r) begin
          state_nxt_s = ST_IDLE;
        end else if (clear_i) begin
          state_nxt_s = ST_CLEAR;
        end else if (win_found_s) begin
          state_nxt_s = ST_GRANT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (clear_i) begin
          state_nxt_s = ST_CLEAR;
        end else if (cdc_ready_i) begin
          state_nxt_s = ST_IDLE;
        end else if (wd_fire_s) begin
          state_nxt_s = ST_CLEAR;
        end else begin
          state_nxt_s = ST_GRANT;
        end
      end
      ST_CLEAR: begin
        if (clr_done_s && !clear_i) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, pointer, holding register and counters.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r     <= ST_IDLE;
      live_r      <= 1'b0;
      ptr_r       <= '0;
      hold_idx_r  <= '0;
      hold_data_r <= '0;
      wd_cnt_r    <= '0;
      clr_cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      live_r  <= 1'b1;
      if (accept_s) begin
        hold_idx_r  <= win_idx_s;
        hold_data_r <= req_data_i[win_idx_s*DATA_WIDTH +: DATA_WIDTH];
        wd_cnt_r    <= '0;
      end else if (state_r == ST_GRANT) begin
        wd_cnt_r <= wd_cnt_r + WD_W'(1);
      end
      // Completed and dropped items both hand priority to the next requester.
      if (handshake_s || drop_s) begin
        ptr_r <= ptr_adv_s;
      end
      if (state_r != ST_CLEAR) begin
        clr_cnt_r <= '0;
      end else if (!clr_done_s) begin
        clr_cnt_r <= clr_cnt_r + CL_W'(1);
      end
    end
  end

  // Outputs; everything is forced low while reset is asserted.
  always_comb begin
    req_ready_o = '0;
    cdc_valid_o = 1'b0;
    cdc_clear_o = 1'b0;
    busy_o      = 1'b0;
    drop_o      = 1'b0;
    timeout_o   = 1'b0;
    cdc_data_o  = '0;
    cdc_idx_o   = '0;
    if (rst_ni) begin
      cdc_data_o = hold_data_r;
      cdc_idx_o  = hold_idx_r;
      busy_o     = (state_r != ST_IDLE);
      case (state_r)
        ST_IDLE:  req_ready_o[win_idx_s] = accept_s;
        ST_GRANT: begin
          cdc_valid_o = !clear_i;
          drop_o      = drop_s;
          timeout_o   = wd_fire_s;
        end
        ST_CLEAR: cdc_clear_o = 1'b1;
        default:  cdc_clear_o = 1'b0;
      endcase
    end else begin
      busy_o = 1'b0;
    end
  end

endmodule
